gelato_ibuffer: RTL and testbench

GELATO_IBUFFER -- requirements
Module: gelato_ibuffer

---
 rtl/gelato_ibuffer.sv | 140 ++++++++++++++
 tb/tb_gelato_ibuffer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gelato_ibuffer.sv
// Per-warp instruction buffer: one circular FIFO per warp between decode and issue,
// with round-robin issue arbitration, per-warp flush and a sticky drop flag.
module gelato_ibuffer #(
   parameter int NUM_WARPS = 4,
   parameter int DEPTH     = 4,
   parameter int INST_W    = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         rdy,
   input  logic                         dec_valid,
   input  logic [$clog2(NUM_WARPS)-1:0] dec_warp,
   input  logic [INST_W-1:0]            dec_inst,
   input  logic [NUM_WARPS-1:0]         flush,
   output logic [NUM_WARPS-1:0]         warp_full,
   output logic [NUM_WARPS-1:0]         warp_afull,
   output logic                         iss_valid,
   output logic [$clog2(NUM_WARPS)-1:0] iss_warp,
   output logic [INST_W-1:0]            iss_inst,
   input  logic                         iss_ready,
   output logic                         overflow
);

   localparam int WW = $clog2(NUM_WARPS);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_CNT = CW'(DEPTH - 1);

   logic [INST_W-1:0] mem_q [NUM_WARPS][DEPTH];

   logic [PW-1:0] wptr_q [NUM_WARPS];
   logic [PW-1:0] wptr_d [NUM_WARPS];
   logic [PW-1:0] rptr_q [NUM_WARPS];
   logic [PW-1:0] rptr_d [NUM_WARPS];
   logic [CW-1:0] cnt_q  [NUM_WARPS];
   logic [CW-1:0] cnt_d  [NUM_WARPS];
   logic [WW-1:0] last_grant_q, last_grant_d;
   logic          overflow_q, overflow_d;

   logic                 found;
   logic [WW-1:0]        sel;
   logic [WW-1:0]        cand;
   logic                 pop;
   logic                 push_req;
   logic                 push_en;
   logic                 push_ovf;
   logic                 tgt_full;
   logic                 pop_tgt;
   logic [NUM_WARPS-1:0] push_vec;
   logic [NUM_WARPS-1:0] pop_vec;

   // Round-robin search starting one past the last granted warp; flushed warps are skipped.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int i = 1; i <= NUM_WARPS; i++) begin
         cand = last_grant_q + WW'(i);
         if (!found && (cnt_q[cand] != '0) && !flush[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   assign iss_valid = found;
   assign iss_warp  = sel;
   assign iss_inst  = mem_q[sel][rptr_q[sel]];
   assign overflow  = overflow_q;

   assign pop      = found & iss_ready & rdy;
   assign tgt_full = (cnt_q[dec_warp] == FULL_CNT);
   assign pop_tgt  = pop & (sel == dec_warp);
   assign push_req = dec_valid & rdy & ~flush[dec_warp];
   // A full warp still accepts a push when it is popped in the same cycle.
   assign push_en  = push_req & (~tgt_full | pop_tgt);
   assign push_ovf = push_req & tgt_full & ~pop_tgt;

   always_comb begin
      for (int w = 0; w < NUM_WARPS; w++) begin
         warp_full[w]  = (cnt_q[w] == FULL_CNT);
         warp_afull[w] = (cnt_q[w] >= AFULL_CNT);
         push_vec[w]   = push_en & (dec_warp == WW'(w));
         pop_vec[w]    = pop & (sel == WW'(w));
      end
   end

   always_comb begin
      wptr_d       = wptr_q;
      rptr_d       = rptr_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      overflow_d   = overflow_q | push_ovf;
      if (pop) begin
         last_grant_d = sel;
      end
      for (int w = 0; w < NUM_WARPS; w++) begin
         if (rdy && flush[w]) begin
            wptr_d[w] = '0;
            rptr_d[w] = '0;
            cnt_d[w]  = '0;
         end else begin
            if (push_vec[w]) begin
               wptr_d[w] = wptr_q[w] + 1'b1;
            end
            if (pop_vec[w]) begin
               rptr_d[w] = rptr_q[w] + 1'b1;
            end
            cnt_d[w] = cnt_q[w] + CW'(push_vec[w]) - CW'(pop_vec[w]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            wptr_q[w] <= '0;
            rptr_q[w] <= '0;
            cnt_q[w]  <= '0;
         end
         last_grant_q <= WW'(NUM_WARPS - 1);
         overflow_q   <= 1'b0;
      end else begin
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         overflow_q   <= overflow_d;
      end
   end

   // Storage carries no reset; only the pointers and counts qualify its contents.
   always_ff @(posedge clk) begin
      if (push_en) begin
         mem_q[dec_warp][wptr_q[dec_warp]] <= dec_inst;
      end
   end

endmodule

// File: tb/tb_gelato_ibuffer.sv
// Bench for gelato_ibuffer: directed scenarios plus a random phase, all checked
// against a queue-based reference model of the per-warp buffers.
module tb_gelato_ibuffer;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        dec_valid;
   logic [1:0]  dec_warp;
   logic [63:0] dec_inst;
   logic [3:0]  flush;
   logic [3:0]  warp_full;
   logic [3:0]  warp_afull;
   logic        iss_valid;
   logic [1:0]  iss_warp;
   logic [63:0] iss_inst;
   logic        iss_ready;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   gelato_ibuffer #(.NUM_WARPS(4), .DEPTH(4), .INST_W(64)) dut (
      .clk        (clk),
      .rst        (rst),
      .rdy        (rdy),
      .dec_valid  (dec_valid),
      .dec_warp   (dec_warp),
      .dec_inst   (dec_inst),
      .flush      (flush),
      .warp_full  (warp_full),
      .warp_afull (warp_afull),
      .iss_valid  (iss_valid),
      .iss_warp   (iss_warp),
      .iss_inst   (iss_inst),
      .iss_ready  (iss_ready),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: one queue per warp, last granted warp, sticky drop flag.
   logic [63:0] mq [4][$];
   int          lg;
   bit          movf;
   logic [63:0] last_d;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [3:0] fl);
      for (int i = 1; i <= 4; i++) begin
         int w;
         w = (lg + i) % 4;
         if (mq[w].size() > 0 && !fl[w]) return w;
      end
      return -1;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 4; k++) mq[k].delete();
      lg   = 3;
      movf = 1'b0;
   endtask

   // Drive one cycle of inputs, compare outputs with the model, advance model and clock.
   task automatic step(input bit v, input int w, input bit ir, input logic [3:0] fl,
                       input bit r, input bit rs);
      logic [63:0] d;
      logic [3:0]  ef;
      logic [3:0]  ea;
      int          ch;
      d         = {$urandom, $urandom};
      last_d    = d;
      dec_valid = v;
      dec_warp  = w[1:0];
      dec_inst  = d;
      iss_ready = ir;
      flush     = fl;
      rdy       = r;
      rst       = rs;
      #2;
      ch = pick(fl);
      chk("iss_valid", {63'b0, iss_valid}, {63'b0, (ch >= 0)});
      if (ch >= 0) begin
         chk("iss_warp", {62'b0, iss_warp}, 64'(ch));
         chk("iss_inst", iss_inst, mq[ch][0]);
      end
      for (int k = 0; k < 4; k++) begin
         ef[k] = (mq[k].size() == 4);
         ea[k] = (mq[k].size() >= 3);
      end
      chk("warp_full", {60'b0, warp_full}, {60'b0, ef});
      chk("warp_afull", {60'b0, warp_afull}, {60'b0, ea});
      chk("overflow", {63'b0, overflow}, {63'b0, movf});
      if (rs) begin
         model_clear();
      end else if (r) begin
         for (int k = 0; k < 4; k++) if (fl[k]) mq[k].delete();
         if (ch >= 0 && ir) begin
            void'(mq[ch].pop_front());
            lg = ch;
         end
         if (v && !fl[w]) begin
            if (mq[w].size() < 4) mq[w].push_back(d);
            else movf = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int w);
      step(1'b1, w, 1'b0, 4'b0, 1'b1, 1'b0);
   endtask

   task automatic idle(input bit ir);
      step(1'b0, 0, ir, 4'b0, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b0, 0, 1'b0, 4'b0, 1'b1, 1'b1);
   endtask

   logic [63:0] pay [5];

   initial begin
      rst = 1'b1; rdy = 1'b1; dec_valid = 1'b0; dec_warp = '0; dec_inst = '0;
      flush = '0; iss_ready = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;

      // Fill warp 2 with issue stalled; the 5th push is dropped
      push(2); push(2); push(2);
      chk("afull2_after3", {63'b0, warp_afull[2]}, 64'd1);
      chk("full2_after3", {63'b0, warp_full[2]}, 64'd0);
      push(2);
      chk("full2_after4", {63'b0, warp_full[2]}, 64'd1);
      push(2);
      chk("ovf_after5", {63'b0, overflow}, 64'd1);
      chk("full2_after5", {63'b0, warp_full[2]}, 64'd1);
      repeat (5) idle(1'b1);

      // Round-robin order after reset: 0, 1, 3
      do_reset();
      push(0); pay[0] = last_d;
      push(1); pay[1] = last_d;
      push(3); pay[2] = last_d;
      chk("rr_first_warp", {62'b0, iss_warp}, 64'd0);
      chk("rr_first_inst", iss_inst, pay[0]);
      idle(1'b1);
      chk("rr_second_warp", {62'b0, iss_warp}, 64'd1);
      chk("rr_second_inst", iss_inst, pay[1]);
      idle(1'b1);
      chk("rr_third_warp", {62'b0, iss_warp}, 64'd3);
      chk("rr_third_inst", iss_inst, pay[2]);
      idle(1'b1);
      chk("rr_drained", {63'b0, iss_valid}, 64'd0);

      // Push and pop a full warp 1 in the same cycle
      for (int i = 0; i < 4; i++) begin
         push(1);
         pay[i] = last_d;
      end
      chk("full1", {63'b0, warp_full[1]}, 64'd1);
      step(1'b1, 1, 1'b1, 4'b0, 1'b1, 1'b0);
      pay[4] = last_d;
      chk("pp_no_ovf", {63'b0, overflow}, 64'd0);
      chk("pp_still_full", {63'b0, warp_full[1]}, 64'd1);
      for (int i = 1; i < 5; i++) begin
         chk("pp_order", iss_inst, pay[i]);
         idle(1'b1);
      end

      // Flush warp 0 together with a push to it
      push(0); push(0); push(0);
      chk("w0_afull", {63'b0, warp_afull[0]}, 64'd1);
      step(1'b1, 0, 1'b0, 4'b0001, 1'b1, 1'b0);
      chk("flush_afull", {60'b0, warp_afull}, 64'd0);
      chk("flush_full", {60'b0, warp_full}, 64'd0);
      chk("flush_valid", {63'b0, iss_valid}, 64'd0);
      chk("flush_ovf", {63'b0, overflow}, 64'd0);
      idle(1'b0);

      // rdy low holds everything
      do_reset();
      push(2); push(2); push(2);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 2, 1'b1, 4'b0, 1'b0, 1'b0);
         chk("stall_afull", {60'b0, warp_afull}, 64'h4);
         chk("stall_full", {60'b0, warp_full}, 64'h0);
      end
      for (int i = 0; i < 4; i++) step(1'b1, 2, 1'b1, 4'b0, 1'b1, 1'b0);
      repeat (4) idle(1'b1);

      // Reset mid-operation with buffered work and overflow set
      for (int i = 0; i < 5; i++) push(3);
      push(0); push(1);
      chk("pre_rst_ovf", {63'b0, overflow}, 64'd1);
      step(1'b0, 0, 1'b0, 4'b0, 1'b1, 1'b1);
      chk("rst_valid", {63'b0, iss_valid}, 64'd0);
      chk("rst_full", {60'b0, warp_full}, 64'd0);
      chk("rst_afull", {60'b0, warp_afull}, 64'd0);
      chk("rst_ovf", {63'b0, overflow}, 64'd0);
      idle(1'b1);

      // Random traffic against the model
      for (int n = 0; n < 600; n++) begin
         bit          v, ir, r, rs;
         int          w;
         logic [3:0]  fl;
         v  = ($urandom_range(0, 99) < 70);
         w  = $urandom_range(0, 3);
         ir = ($urandom_range(0, 99) < 45);
         fl = ($urandom_range(0, 99) < 6) ? 4'($urandom_range(1, 15)) : 4'b0;
         r  = ($urandom_range(0, 99) < 90);
         rs = ($urandom_range(0, 199) < 2);
         step(v, w, ir, fl, r, rs);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
